mux_arb_2x1: RTL and testbench
==============================

MUX_ARB_2X1 -- requirements
Module: mux_arb_2x1

Interface
REQ-001 Parameter WIDTH, default 8, data width of each source and of the output.
REQ-002 Parameter MAX_BURST, default 4, maximum back-to-back transfers per grant; legal range 1..15.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  asynchronous reset, active-low.
REQ-005 a_valid  input  1  source A offers a_data.
REQ-006 a_data  input  WIDTH  source A payload.
REQ-007 a_ready  output  1  source A transfer accepted this cycle.
REQ-008 b_valid  input  1  source B offers b_data.
REQ-009 b_data  input  WIDTH  source B payload.
REQ-010 b_ready  output  1  source B transfer accepted this cycle.
REQ-011 select  output  1  drives the downstream 2:1 mux select; 1 = source A, 0 = source B.
REQ-012 out_valid  output  1  out_data holds an undelivered word.
REQ-013 out_data  output  WIDTH  registered selected word.
REQ-014 out_ready  input  1  consumer accepts out_data this cycle.
REQ-015 busy  output  1  high when state != IDLE or out_valid = 1.

Function
REQ-016 FSM states: IDLE, GRANT_A, GRANT_B; state, select, burst count, last-grant flag and output register are registered.
REQ-017 select = 1 in GRANT_A, 0 in GRANT_B; in IDLE it holds the last granted value.
REQ-018 can_load = !out_valid | out_ready; a_ready = (state==GRANT_A) & can_load; b_ready = (state==GRANT_B) & can_load; both combinational, never high together.
REQ-019 Transfer on a source = its valid & ready in the same cycle; on transfer out_data loads that source's data and out_valid = 1 next cycle.
REQ-020 out_valid clears next cycle when out_ready = 1 and no transfer occurs; out_data holds its value while out_valid = 1 and out_ready = 0.
REQ-021 IDLE: only a_valid -> GRANT_A; only b_valid -> GRANT_B; both -> grant the source opposite the last-grant flag; neither -> stay IDLE.
REQ-022 Grant latency: valid asserted at cycle N in IDLE -> ready at N+1 -> out_valid at N+2.
REQ-023 Burst counter, width 4, cleared on entry to any grant state; increments on each transfer of the granted source; no change on stall cycles.
REQ-024 Grant ends when (transfer and counter reaches MAX_BURST) or (granted source valid = 0).
REQ-025 At grant end: other source valid -> switch directly to its grant state (no IDLE cycle); else current source still valid -> re-enter same grant, counter cleared; else -> IDLE.
REQ-026 Last-grant flag updates on every entry to a grant state.
REQ-027 MAX_BURST = 1 with both sources continuously valid: strict alternation A,B,A,B...
REQ-028 Stall (out_ready = 0, out_valid = 1): both readies low, state and counter frozen; valid drop by the granted source during stall still ends the grant per REQ-024.
REQ-029 Data ordering per source is preserved; no word is duplicated or dropped.

Reset
REQ-030 rst_n = 0 forces immediately: state = IDLE, select = 0, out_valid = 0, out_data = 0, counter = 0, last-grant = B (so A wins the first tie); a_ready = b_ready = 0, busy = 0.
REQ-031 Reset mid-burst discards the output register contents; no transfer completes in a reset cycle.
REQ-032 First grant decision occurs on the first rising edge after rst_n deasserts.

Verification
REQ-033 Reset then a_valid=1, a_data=8'h11, out_ready=1 -> a_ready at cycle 1, out_valid with 8'h11 at cycle 2, select=1.
REQ-034 Both valid continuously, MAX_BURST=4, out_ready=1 -> output order 4 A words, 4 B words, repeating; select toggles with each burst; no bubble at switch.
REQ-035 MAX_BURST=1, both valid -> A,B,A,B, starting with A after reset.
REQ-036 GRANT_A active, out_ready held 0 for 5 cycles -> out_data constant, a_ready=0, counter unchanged; release -> burst resumes, total A words = 4.
REQ-037 Only b_valid, 10 words, MAX_BURST=4 -> all 10 words delivered in order, select=0 throughout, re-entry after each 4.
REQ-038 rst_n pulsed low mid-burst with out_valid=1 -> out_valid=0, state IDLE asynchronously; next tie grants A.

Source files
------------

// File: rtl/mux_arb_2x1.sv
// Two-source round-robin arbiter feeding a registered 2:1 output stage.
// Grants run in bursts of up to MAX_BURST transfers; ties alternate using a last-grant flag.
module mux_arb_2x1 #(
  parameter int WIDTH     = 8,
  parameter int MAX_BURST = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             a_valid,
  input  logic [WIDTH-1:0] a_data,
  output logic             a_ready,
  input  logic             b_valid,
  input  logic [WIDTH-1:0] b_data,
  output logic             b_ready,
  output logic             select,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_A = 2'd1,
    GRANT_B = 2'd2
  } state_t;

  localparam logic [3:0] BURST_LIM = 4'(MAX_BURST);

  state_t     state, state_nxt;
  logic [3:0] burst_cnt;
  logic       last_a;
  logic       can_load;
  logic       xfer_a, xfer_b, xfer_cur;
  logic       cur_valid, oth_valid;
  logic       grant_end;
  logic       enter_grant;

  assign can_load = !out_valid || out_ready;
  assign xfer_a   = a_valid && a_ready;
  assign xfer_b   = b_valid && b_ready;

  // State, burst counter, last-grant flag and select
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      burst_cnt <= '0;
      last_a    <= 1'b0;
      select    <= 1'b0;
    end else begin
      state <= state_nxt;
      if (enter_grant) begin
        burst_cnt <= '0;
        last_a    <= (state_nxt == GRANT_A);
        select    <= (state_nxt == GRANT_A);
      end else if (xfer_cur) begin
        burst_cnt <= burst_cnt + 4'd1;
      end
    end
  end

  // Next-state: grant end is checked on the granted source only; re-entry counts as a fresh grant
  always_comb begin
    state_nxt   = state;
    enter_grant = 1'b0;
    cur_valid   = 1'b0;
    oth_valid   = 1'b0;
    xfer_cur    = 1'b0;
    grant_end   = 1'b0;
    case (state)
      IDLE: begin
        if (a_valid && b_valid) state_nxt = last_a ? GRANT_B : GRANT_A;
        else if (a_valid)       state_nxt = GRANT_A;
        else if (b_valid)       state_nxt = GRANT_B;
        enter_grant = (state_nxt != IDLE);
      end
      GRANT_A, GRANT_B: begin
        cur_valid = (state == GRANT_A) ? a_valid : b_valid;
        oth_valid = (state == GRANT_A) ? b_valid : a_valid;
        xfer_cur  = (state == GRANT_A) ? xfer_a  : xfer_b;
        grant_end = (xfer_cur && (burst_cnt + 4'd1 == BURST_LIM)) || !cur_valid;
        if (grant_end) begin
          if (oth_valid)      state_nxt = (state == GRANT_A) ? GRANT_B : GRANT_A;
          else if (cur_valid) state_nxt = state;
          else                state_nxt = IDLE;
          enter_grant = (state_nxt != IDLE);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    a_ready = (state == GRANT_A) && can_load;
    b_ready = (state == GRANT_B) && can_load;
    busy    = (state != IDLE) || out_valid;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (xfer_a) begin
      out_valid <= 1'b1;
      out_data  <= a_data;
    end else if (xfer_b) begin
      out_valid <= 1'b1;
      out_data  <= b_data;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mux_arb_2x1.sv
// Bench for mux_arb_2x1: directed scenarios plus randomized traffic against a transaction-level model.
module tb_mux_arb_2x1;
  localparam int MB = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       a_valid, b_valid, out_ready;
  logic [7:0] a_data, b_data;
  logic       a_ready, b_ready, select, out_valid, busy;
  logic [7:0] out_data;
  logic       a_ready1, b_ready1, select1, out_valid1, busy1;
  logic [7:0] out_data1;

  int n_checks = 0;
  int n_pass   = 0;

  // model: owner 0 = none, 1 = A, 2 = B
  int         m_owner, m_cnt, m_last;
  bit         m_sel, m_ov;
  logic [7:0] m_od;
  bit         e_ar, e_br;
  logic [7:0] a_next, b_next;

  mux_arb_2x1 #(.WIDTH(8), .MAX_BURST(MB)) dut (
    .clk(clk), .rst_n(rst_n),
    .a_valid(a_valid), .a_data(a_data), .a_ready(a_ready),
    .b_valid(b_valid), .b_data(b_data), .b_ready(b_ready),
    .select(select), .out_valid(out_valid), .out_data(out_data),
    .out_ready(out_ready), .busy(busy)
  );

  mux_arb_2x1 #(.WIDTH(8), .MAX_BURST(1)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .a_valid(a_valid), .a_data(a_data), .a_ready(a_ready1),
    .b_valid(b_valid), .b_data(b_data), .b_ready(b_ready1),
    .select(select1), .out_valid(out_valid1), .out_data(out_data1),
    .out_ready(out_ready), .busy(busy1)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_owner = 0; m_cnt = 0; m_last = 2; m_sel = 0; m_ov = 0; m_od = '0;
    a_next = 8'h10; b_next = 8'h80;
  endtask

  task automatic model_eval();
    bit can;
    can  = !m_ov || out_ready;
    e_ar = (m_owner == 1) && can;
    e_br = (m_owner == 2) && can;
  endtask

  task automatic model_advance();
    bit xa, xb, mine, other;
    int nc;
    xa = a_valid && e_ar;
    xb = b_valid && e_br;
    if (xa)             begin m_od = a_data; m_ov = 1; a_next++; end
    else if (xb)        begin m_od = b_data; m_ov = 1; b_next++; end
    else if (out_ready) m_ov = 0;
    if (m_owner == 0) begin
      if (a_valid && b_valid) m_owner = (m_last == 1) ? 2 : 1;
      else if (a_valid)       m_owner = 1;
      else if (b_valid)       m_owner = 2;
      if (m_owner != 0) begin m_cnt = 0; m_last = m_owner; end
    end else begin
      mine  = (m_owner == 1) ? a_valid : b_valid;
      other = (m_owner == 1) ? b_valid : a_valid;
      nc    = m_cnt + ((xa || xb) ? 1 : 0);
      if (((xa || xb) && nc == MB) || !mine) begin
        if (other)      m_owner = 3 - m_owner;
        else if (!mine) m_owner = 0;
        m_cnt = 0;
        if (m_owner != 0) m_last = m_owner;
      end else begin
        m_cnt = nc;
      end
    end
    if (m_owner != 0) m_sel = (m_owner == 1);
  endtask

  task automatic apply_reset();
    rst_n = 1'b0; a_valid = 0; b_valid = 0; out_ready = 1;
    a_data = '0; b_data = '0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; a_valid = 1; b_valid = 1; out_ready = 1;
    a_data = 8'hAA; b_data = 8'hBB;
    #2;
    n_checks++; if (a_ready !== 1'b0 || b_ready !== 1'b0) $display("FAIL reset_ready: got %b%b want 00", a_ready, b_ready); else n_pass++;
    n_checks++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", out_valid); else n_pass++;
    n_checks++; if (out_data !== 8'h00) $display("FAIL reset_out_data: got %h want 00", out_data); else n_pass++;
    n_checks++; if (busy !== 1'b0 || select !== 1'b0) $display("FAIL reset_busy_select: got %b%b want 00", busy, select); else n_pass++;
  endtask

  task automatic test_first_grant();
    apply_reset();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      a_valid = (i < 2); a_data = 8'h11; b_valid = 0; out_ready = 1;
      #1;
      if (i == 0) begin
        n_checks++; if (a_ready !== 1'b0) $display("FAIL first_a_ready_c0: got %b want 0", a_ready); else n_pass++;
      end
      if (i == 1) begin
        n_checks++; if (a_ready !== 1'b1) $display("FAIL first_a_ready_c1: got %b want 1", a_ready); else n_pass++;
      end
      if (i == 2) begin
        n_checks++; if (out_valid !== 1'b1 || out_data !== 8'h11) $display("FAIL first_out_c2: got %b/%h want 1/11", out_valid, out_data); else n_pass++;
        n_checks++; if (select !== 1'b1) $display("FAIL first_select: got %b want 1", select); else n_pass++;
      end
    end
  endtask

  task automatic test_back_to_back();
    int k;
    bit got_a;
    apply_reset();
    k = 0;
    for (int i = 0; i < 26; i++) begin
      @(negedge clk);
      a_valid = 1; a_data = a_next; b_valid = 1; b_data = b_next; out_ready = 1;
      #1;
      model_eval();
      n_checks++; if (a_ready !== e_ar || b_ready !== e_br) $display("FAIL b2b_ready cyc %0d: got %b%b want %b%b", i, a_ready, b_ready, e_ar, e_br); else n_pass++;
      n_checks++; if (out_valid !== m_ov || out_data !== m_od) $display("FAIL b2b_out cyc %0d: got %b/%h want %b/%h", i, out_valid, out_data, m_ov, m_od); else n_pass++;
      n_checks++; if (select !== m_sel) $display("FAIL b2b_select cyc %0d: got %b want %b", i, select, m_sel); else n_pass++;
      if (out_valid && out_ready && k < 16) begin
        got_a = (out_data < 8'h80);
        n_checks++; if (got_a !== (((k / 4) % 2) == 0)) $display("FAIL b2b_order word %0d: got A=%b want A=%b", k, got_a, ((k / 4) % 2) == 0); else n_pass++;
        k++;
      end
      @(posedge clk);
      model_advance();
    end
    n_checks++; if (k != 16) $display("FAIL b2b_count: got %0d want 16", k); else n_pass++;
  endtask

  task automatic test_max_burst_one();
    apply_reset();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      a_valid = 1; b_valid = 1; a_data = 8'h21; b_data = 8'h91; out_ready = 1;
      #1;
      if (i >= 1) begin
        n_checks++;
        if (a_ready1 !== (i % 2 == 1) || b_ready1 !== (i % 2 == 0))
          $display("FAIL mb1_alternate cyc %0d: got %b%b want %b%b", i, a_ready1, b_ready1, i % 2 == 1, i % 2 == 0);
        else n_pass++;
      end
      @(posedge clk);
    end
  endtask

  task automatic test_stall();
    int  n_a;
    bit  seen_b, tx_a, tx_b;
    apply_reset();
    n_a = 0; seen_b = 0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      a_valid = 1; a_data = a_next; b_valid = 1; b_data = b_next;
      out_ready = !(i >= 4 && i <= 8);
      #1;
      if (i >= 4 && i <= 8) begin
        n_checks++; if (a_ready !== 1'b0 || b_ready !== 1'b0) $display("FAIL stall_ready cyc %0d: got %b%b want 00", i, a_ready, b_ready); else n_pass++;
        n_checks++; if (out_data !== 8'h12 || out_valid !== 1'b1) $display("FAIL stall_hold cyc %0d: got %b/%h want 1/12", i, out_valid, out_data); else n_pass++;
      end
      if (i == 9) begin
        n_checks++; if (a_ready !== 1'b1) $display("FAIL stall_resume: got %b want 1", a_ready); else n_pass++;
      end
      if (out_valid && out_ready) begin
        if (out_data >= 8'h80) seen_b = 1;
        else if (!seen_b) n_a++;
      end
      tx_a = a_valid && a_ready;
      tx_b = b_valid && b_ready;
      @(posedge clk);
      if (tx_a) a_next++;
      if (tx_b) b_next++;
    end
    n_checks++; if (n_a != 4 || !seen_b) $display("FAIL stall_burst_len: got %0d A words (B seen %b) want 4 (1)", n_a, seen_b); else n_pass++;
  endtask

  task automatic test_only_b();
    int  sent, got;
    bit  tx;
    apply_reset();
    sent = 0; got = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      a_valid = 0; b_valid = (sent < 10); b_data = b_next; out_ready = 1;
      #1;
      if (i >= 1 && i <= 10) begin
        n_checks++; if (b_ready !== 1'b1) $display("FAIL onlyb_ready cyc %0d: got %b want 1", i, b_ready); else n_pass++;
      end
      if (i >= 12) begin
        n_checks++; if (b_ready !== 1'b0 || busy !== 1'b0) $display("FAIL onlyb_idle cyc %0d: got %b%b want 00", i, b_ready, busy); else n_pass++;
      end
      n_checks++; if (select !== 1'b0) $display("FAIL onlyb_select cyc %0d: got %b want 0", i, select); else n_pass++;
      if (out_valid && out_ready) begin
        n_checks++; if (out_data !== 8'(8'h80 + got)) $display("FAIL onlyb_data word %0d: got %h want %h", got, out_data, 8'(8'h80 + got)); else n_pass++;
        got++;
      end
      tx = b_valid && b_ready;
      @(posedge clk);
      if (tx) begin b_next++; sent++; end
    end
    n_checks++; if (got != 10) $display("FAIL onlyb_count: got %0d want 10", got); else n_pass++;
  endtask

  task automatic test_random();
    apply_reset();
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      a_valid = ($urandom_range(9) < 7); a_data = a_next;
      b_valid = ($urandom_range(9) < 6); b_data = b_next;
      out_ready = ($urandom_range(9) < 7);
      #1;
      model_eval();
      n_checks++; if (a_ready !== e_ar || b_ready !== e_br) $display("FAIL rnd_ready cyc %0d: got %b%b want %b%b", i, a_ready, b_ready, e_ar, e_br); else n_pass++;
      n_checks++; if (out_valid !== m_ov || out_data !== m_od) $display("FAIL rnd_out cyc %0d: got %b/%h want %b/%h", i, out_valid, out_data, m_ov, m_od); else n_pass++;
      n_checks++; if (select !== m_sel || busy !== (m_owner != 0 || m_ov)) $display("FAIL rnd_sel_busy cyc %0d: got %b%b want %b%b", i, select, busy, m_sel, m_owner != 0 || m_ov); else n_pass++;
      @(posedge clk);
      model_advance();
    end
  endtask

  task automatic test_reset_mid_burst();
    apply_reset();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      a_valid = 1; a_data = a_next; b_valid = 1; b_data = b_next; out_ready = 1;
      #1;
      if (i == 3) begin
        n_checks++; if (out_valid !== 1'b1) $display("FAIL midrst_pre: got %b want 1", out_valid); else n_pass++;
        #1 rst_n = 1'b0;
        #1;
        n_checks++; if (out_valid !== 1'b0 || out_data !== 8'h00) $display("FAIL midrst_out: got %b/%h want 0/00", out_valid, out_data); else n_pass++;
        n_checks++; if (busy !== 1'b0 || a_ready !== 1'b0 || b_ready !== 1'b0 || select !== 1'b0) $display("FAIL midrst_state: got busy=%b rdy=%b%b sel=%b want 0 00 0", busy, a_ready, b_ready, select); else n_pass++;
      end else begin
        @(posedge clk);
        a_next++;
      end
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    n_checks++; if (a_ready !== 1'b1 || b_ready !== 1'b0) $display("FAIL midrst_tie: got %b%b want 10", a_ready, b_ready); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_first_grant();
    test_back_to_back();
    test_max_burst_one();
    test_stall();
    test_only_b();
    test_random();
    test_reset_mid_burst();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running want finished");
    $fatal(1, "timeout");
  end

endmodule
